// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: widths, ALU control encoding, FSM states.
package ex_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CTL_W = 4;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned STEPS = 32;

  typedef enum logic [CTL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REMU = 4'd12
  } alu_op_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Ops that go through the iterative multiply/divide unit.
  function automatic logic is_multicycle(input logic [CTL_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative 32-step unsigned multiply (shift-add) and restoring divide.
// Result and done are combinational views of the step being taken this cycle,
// so the caller can register the final result on the 32nd step edge.
module mul_div_iter
  import ex_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             abort_i,
  input  logic [CTL_W-1:0] op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic             done_c_o,
  output logic [XLEN-1:0]  result_c_o
);

  logic [CTL_W-1:0]  op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;

  // Next-state for operands, counter and accumulator/remainder.
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge = (rem_sh >= {1'b0, b_q});
    if (start_i) begin
      op_d  = op_i;
      a_d   = a_i;
      b_d   = b_i;
      cnt_d = '0;
      acc_d = (op_i == ALU_MUL) ? (2*XLEN)'(0) : {XLEN'(0), a_i};
    end else if (abort_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (op_q == ALU_MUL) begin
        // Low half holds the running product; multiplicand shifts up, multiplier down.
        if (b_q[0]) begin
          acc_d[XLEN-1:0] = acc_q[XLEN-1:0] + a_q;
        end
        a_d = a_q << 1;
        b_d = b_q >> 1;
      end else begin
        // {remainder, quotient} shifts left; subtract divisor when it fits.
        if (rem_ge) begin
          acc_d = {rem_sh[XLEN-1:0] - b_q, acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign done_c_o   = step_i && (cnt_q == CNT_W'(STEPS - 1));
  assign result_c_o = (op_q == ALU_REMU) ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];

  // Operand latches, step counter and accumulator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// RISC-V EX stage: single-cycle ALU, iterative MUL/DIVU/REMU with upstream stall,
// flush of the EX slot, and the EX/MEM pipeline register.
module execute_stage
  import ex_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [CTL_W-1:0] ALU_ctrl_in,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  input  logic [REG_W-1:0] rd_in,
  input  logic             reg_write_in,
  input  logic             flush,
  output logic             stall,
  output logic [XLEN-1:0]  result_out,
  output logic [REG_W-1:0] rd_out,
  output logic             reg_write_out,
  output logic             valid_out
);

  logic [0:0]       state_q, state_d;
  logic             stall_q, stall_d;
  logic             valid_q, valid_d;
  logic             rw_q, rw_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [REG_W-1:0] rd_pend_q, rd_pend_d;
  logic             rw_pend_q, rw_pend_d;

  logic [XLEN-1:0]  alu_res;
  logic             accept;
  logic             rw_in;
  logic             md_start, md_step, md_abort, md_done;
  logic [XLEN-1:0]  md_result;

  assign accept = in_valid && !stall_q && !flush;
  assign rw_in  = reg_write_in && (rd_in != REG_W'(0));

  // Single-cycle ALU; multi-cycle and reserved codes yield 0 here.
  always_comb begin
    alu_res = '0;
    case (ALU_ctrl_in)
      ALU_ADD:  alu_res = operand_a + operand_b;
      ALU_SUB:  alu_res = operand_a - operand_b;
      ALU_AND:  alu_res = operand_a & operand_b;
      ALU_OR:   alu_res = operand_a | operand_b;
      ALU_XOR:  alu_res = operand_a ^ operand_b;
      ALU_SLL:  alu_res = operand_a << operand_b[4:0];
      ALU_SRL:  alu_res = operand_a >> operand_b[4:0];
      ALU_SRA:  alu_res = XLEN'($signed(operand_a) >>> operand_b[4:0]);
      ALU_SLT:  alu_res = XLEN'($signed(operand_a) < $signed(operand_b));
      ALU_SLTU: alu_res = XLEN'(operand_a < operand_b);
      default:  alu_res = '0;
    endcase
  end

  mul_div_iter u_mul_div (
    .clock      (clock),
    .reset      (reset),
    .start_i    (md_start),
    .step_i     (md_step),
    .abort_i    (md_abort),
    .op_i       (ALU_ctrl_in),
    .a_i        (operand_a),
    .b_i        (operand_b),
    .done_c_o   (md_done),
    .result_c_o (md_result)
  );

  // FSM next state, EX/MEM load and multiply/divide control.
  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    rw_d      = 1'b0;
    rd_d      = rd_q;
    result_d  = result_q;
    rd_pend_d = rd_pend_q;
    rw_pend_d = rw_pend_q;
    md_start  = 1'b0;
    md_step   = 1'b0;
    md_abort  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_multicycle(ALU_ctrl_in)) begin
            md_start  = 1'b1;
            rd_pend_d = rd_in;
            rw_pend_d = rw_in;
            state_d   = ST_BUSY;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            rd_d     = rd_in;
            rw_d     = rw_in;
          end
        end
      end
      ST_BUSY: begin
        // Flush abandons the op, even on its final step.
        if (flush) begin
          md_abort = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          md_step = 1'b1;
          if (md_done) begin
            valid_d  = 1'b1;
            result_d = md_result;
            rd_d     = rd_pend_q;
            rw_d     = rw_pend_q;
            state_d  = ST_IDLE;
          end
        end
      end
    endcase
    stall_d = (state_d == ST_BUSY);
  end

  // State and EX/MEM pipeline register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      stall_q   <= 1'b0;
      valid_q   <= 1'b0;
      rw_q      <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      rd_pend_q <= '0;
      rw_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      valid_q   <= valid_d;
      rw_q      <= rw_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      rd_pend_q <= rd_pend_d;
      rw_pend_q <= rw_pend_d;
    end
  end

  assign stall         = stall_q;
  assign valid_out     = valid_q;
  assign reg_write_out = rw_q;
  assign rd_out        = rd_q;
  assign result_out    = result_q;

endmodule
